// File: rtl/weight_pkg.sv
// Shared types and helpers for the weight memory loader.
// The TRANSPOSE_EN build option uses transpose_addr() to remap row-major streams.
package weight_pkg;

    localparam int unsigned WEIGHT_W = 5;
    localparam int unsigned SIZE     = 8;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        FULL    = 2'd1,
        PRELOAD = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    // Swaps the low half_w bits of addr with the bits above them.
    function automatic logic [15:0] transpose_addr(input logic [15:0] addr,
                                                   input int unsigned half_w);
        logic [15:0] low_mask;
        low_mask = 16'((32'd1 << half_w) - 32'd1);
        return ((addr & low_mask) << half_w) | (addr >> half_w);
    endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Stream, memory-port and status signals of the weight loader.
// slave is the loader's view; master is the host/memory side.
interface weight_loader_if #(
    parameter int unsigned SIZE = 8
);
    import weight_pkg::*;

    localparam int unsigned WRITE_ADDR_WIDTH = $clog2(SIZE * SIZE);
    localparam int unsigned READ_ADDR_WIDTH  = $clog2(SIZE);

    logic                        In_Valid;
    logic [WEIGHT_W-1:0]         In_Data;
    logic                        In_Ready;
    logic                        Preload_Start;
    logic [WRITE_ADDR_WIDTH-1:0] Wr_Addr;
    logic [WEIGHT_W-1:0]         Weight_Data;
    logic                        Wr_en;
    logic                        Rd_en;
    logic [READ_ADDR_WIDTH-1:0]  Rd_Addr;
    logic                        Col_Valid;
    logic                        Loaded;
    logic                        Busy;

    modport slave (
        input  In_Valid,
        input  In_Data,
        input  Preload_Start,
        output In_Ready,
        output Wr_Addr,
        output Weight_Data,
        output Wr_en,
        output Rd_en,
        output Rd_Addr,
        output Col_Valid,
        output Loaded,
        output Busy
    );

    modport master (
        output In_Valid,
        output In_Data,
        output Preload_Start,
        input  In_Ready,
        input  Wr_Addr,
        input  Weight_Data,
        input  Wr_en,
        input  Rd_en,
        input  Rd_Addr,
        input  Col_Valid,
        input  Loaded,
        input  Busy
    );

endinterface

// File: rtl/weight_rd_seq.sv
// Column read sequencer: SIZE read cycles from column SIZE-1 down to 0,
// with Col_Valid trailing Rd_en by one cycle for the registered memory read.
module weight_rd_seq #(
    parameter int unsigned SIZE   = 8,
    parameter int unsigned ADDR_W = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              col_valid,
    output logic              last
);

    logic              active_q, active_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              cv_q, cv_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        cv_d     = active_q;
        if (start && !active_q) begin
            active_d = 1'b1;
            cnt_d    = ADDR_W'(SIZE - 1);
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            cv_q     <= 1'b0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            cv_q     <= cv_d;
        end
    end

    assign rd_en     = active_q;
    assign rd_addr   = cnt_q;
    assign col_valid = cv_q;
    assign last      = active_q && (cnt_q == '0);

endmodule

// File: rtl/weight_loader.sv
// Weight memory write controller and preload sequencer for a SIZE x SIZE array.
// Define TRANSPOSE_EN to accept a row-major stream (write address halves swapped).
module weight_loader #(
    parameter int unsigned SIZE = weight_pkg::SIZE
) (
    input  logic           clk,
    input  logic           rst_n,
    weight_loader_if.slave bus
);
    import weight_pkg::*;

    localparam int unsigned MEM_SIZE         = SIZE * SIZE;
    localparam int unsigned WRITE_ADDR_WIDTH = $clog2(MEM_SIZE);
    localparam int unsigned READ_ADDR_WIDTH  = $clog2(SIZE);

    state_e                      state_q, state_d;
    logic [WRITE_ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WRITE_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, map_addr;
    logic [WEIGHT_W-1:0]         wr_data_q, wr_data_d;
    logic                        wr_en_q, wr_en_d;
    logic                        ready_q, ready_d;
    logic                        loaded_q, loaded_d;
    logic                        handshake;
    logic                        start_sweep;
    logic                        rd_en;
    logic [READ_ADDR_WIDTH-1:0]  rd_addr;
    logic                        col_valid;
    logic                        rd_last;

    assign handshake = bus.In_Valid && ready_q;

`ifdef TRANSPOSE_EN
    assign map_addr = WRITE_ADDR_WIDTH'(transpose_addr(16'(wcnt_q), READ_ADDR_WIDTH));
`else
    assign map_addr = wcnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        loaded_d    = loaded_q;
        start_sweep = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (handshake) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = map_addr;
                    wr_data_d = bus.In_Data;
                    // Counter parks at the last address; FULL blocks any further write.
                    if (wcnt_q == WRITE_ADDR_WIDTH'(MEM_SIZE - 1)) begin
                        state_d  = FULL;
                        loaded_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.Preload_Start) begin
                    start_sweep = 1'b1;
                    state_d     = PRELOAD;
                end
            end
            PRELOAD: begin
                if (rd_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = FULL;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
        // Registered so In_Ready is low while reset is held.
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            wcnt_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            loaded_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            ready_q   <= ready_d;
            loaded_q  <= loaded_d;
        end
    end

    weight_rd_seq #(
        .SIZE   (SIZE),
        .ADDR_W (READ_ADDR_WIDTH)
    ) u_rd_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_sweep),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .col_valid (col_valid),
        .last      (rd_last)
    );

    assign bus.In_Ready    = ready_q;
    assign bus.Wr_en       = wr_en_q;
    assign bus.Wr_Addr     = wr_addr_q;
    assign bus.Weight_Data = wr_data_q;
    assign bus.Rd_en       = rd_en;
    assign bus.Rd_Addr     = rd_addr;
    assign bus.Col_Valid   = col_valid;
    assign bus.Loaded      = loaded_q;
    assign bus.Busy        = (state_q == PRELOAD) || (state_q == DRAIN) ||
                             ((state_q == LOAD) && (wcnt_q != '0));

    // The memory gives writes priority, so a read must never coincide with one.
    a_no_rd_wr_overlap : assert property (@(posedge clk) disable iff (!rst_n)
                                          !(rd_en && wr_en_q));

endmodule

// File: tb/tb_weight_loader.sv
// Randomized self-checking bench for weight_loader against a queue-based reference model.
module tb_weight_loader;
    import weight_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned MEM = N * N;

    logic clk;
    logic rst_n;

    weight_loader_if #(.SIZE(N)) bus ();

    weight_loader #(.SIZE(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_nwr;
    bit m_loaded, m_ready, m_wr, m_rd, m_cv;
    int m_wa, m_wd, m_ra;
    int m_last_wa;
    int rd_plan[$];
    int n_wr_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int k);
`ifdef TRANSPOSE_EN
        return (k % N) * N + (k / N);
`else
        return k;
`endif
    endfunction

    task automatic model_reset();
        m_nwr     = 0;
        m_loaded  = 0;
        m_ready   = 0;
        m_wr      = 0;
        m_rd      = 0;
        m_cv      = 0;
        m_wa      = 0;
        m_wd      = 0;
        m_ra      = 0;
        n_wr_seen = 0;
        rd_plan.delete();
    endtask

    // Advance one clock, update the model from the pre-edge inputs, then compare.
    task automatic step();
        bit hs;
        bit st;
        int d;
        hs = bus.In_Valid && m_ready;
        st = bus.Preload_Start && m_loaded && !m_rd && !m_cv;
        d  = int'(bus.In_Data);
        @(posedge clk);
        #1;
        m_wr = hs;
        if (hs) begin
            m_wa      = exp_addr(m_nwr);
            m_wd      = d;
            m_last_wa = m_wa;
            m_nwr++;
            if (m_nwr == MEM) m_loaded = 1;
        end
        m_cv = m_rd;
        if (st) begin
            for (int a = N - 1; a >= 0; a--) rd_plan.push_back(a);
        end
        if (rd_plan.size() != 0) begin
            m_rd = 1;
            m_ra = rd_plan.pop_front();
        end else begin
            m_rd = 0;
        end
        m_ready = !m_loaded;

        if (bus.Wr_en === 1'b1) n_wr_seen++;
        check_eq("wr_en", bus.Wr_en, m_wr);
        if (m_wr) begin
            check_eq("wr_addr", bus.Wr_Addr, m_wa);
            check_eq("wr_data", bus.Weight_Data, m_wd);
        end
        check_eq("rd_en", bus.Rd_en, m_rd);
        if (m_rd) check_eq("rd_addr", bus.Rd_Addr, m_ra);
        check_eq("col_valid", bus.Col_Valid, m_cv);
        check_eq("loaded", bus.Loaded, m_loaded);
        check_eq("busy", bus.Busy, (!m_loaded && m_nwr != 0) || m_rd || m_cv);
        check_eq("in_ready", bus.In_Ready, m_ready);
    endtask

    task automatic drive(input bit v, input int d, input bit p);
        bus.In_Valid      = v;
        bus.In_Data       = 5'(d);
        bus.Preload_Start = p;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_en"}, bus.Wr_en, 0);
        check_eq({tag, "_rd_en"}, bus.Rd_en, 0);
        check_eq({tag, "_col_valid"}, bus.Col_Valid, 0);
        check_eq({tag, "_loaded"}, bus.Loaded, 0);
        check_eq({tag, "_busy"}, bus.Busy, 0);
        check_eq({tag, "_in_ready"}, bus.In_Ready, 0);
    endtask

    initial begin
        n_checks          = 0;
        n_fail            = 0;
        m_last_wa         = -1;
        rst_n             = 1'b0;
        bus.In_Valid      = 1'b0;
        bus.In_Data       = '0;
        bus.Preload_Start = 1'b0;
        model_reset();

        #23;
        check_reset_outputs("por");
        check_eq("por_wr_addr", bus.Wr_Addr, 0);
        check_eq("por_rd_addr", bus.Rd_Addr, 0);
        rst_n = 1'b1;

        // Continuous stream, data k%32; a preload pulse at wcnt=10 must be ignored.
        for (int c = 0; c < 100 && !m_loaded; c++) begin
            drive(1'b1, m_nwr % 32, m_nwr == 10);
        end
        check_eq("stream1_loaded", bus.Loaded, 1);
        check_eq("stream1_ready", bus.In_Ready, 0);
        check_eq("stream1_last_addr", m_last_wa, exp_addr(MEM - 1));
        check_eq("stream1_write_count", n_wr_seen, MEM);

        // Valid held high in FULL: nothing accepted.
        for (int c = 0; c < 4; c++) drive(1'b1, $urandom_range(0, 31), 1'b0);

        // Sweep, with ignored pulses during PRELOAD and DRAIN, then a replay.
        drive(1'b0, 0, 1'b1);
        for (int c = 0; c < 12; c++) drive(1'b0, 0, (c == 3) || (c == 8));
        drive(1'b0, 0, 1'b1);
        for (int c = 0; c < 11; c++) drive(1'b0, 0, 1'b0);

        // Asynchronous reset in the third PRELOAD cycle.
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b0);
        check_eq("pre_rst_rd_en", bus.Rd_en, 1);
        check_eq("pre_rst_col_valid", bus.Col_Valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        #3;
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0);
        check_eq("post_rst_ready", bus.In_Ready, 1);
        check_eq("post_rst_busy", bus.Busy, 0);

        // Toggled valid 1,0,1,0 first, then random valid, data and preload pulses.
        for (int c = 0; c < 600 && !m_loaded; c++) begin
            if (c < 20) drive(c % 2 == 0, $urandom_range(0, 31), 1'b0);
            else drive($urandom_range(0, 1) == 1, $urandom_range(0, 31),
                       $urandom_range(0, 15) == 0);
        end
        check_eq("stream2_loaded", bus.Loaded, 1);
        check_eq("stream2_last_addr", m_last_wa, exp_addr(MEM - 1));
        check_eq("stream2_write_count", n_wr_seen, MEM);

        // Random preload pulses and stray valids while full.
        for (int c = 0; c < 80; c++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 5) == 0);
        end
        for (int c = 0; c < 12; c++) drive(1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
